// File: rtl/mdc_stream_pkg.sv
// Shared types and constants for the MDC token-to-stream output packer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mdc_stream_pkg;

    localparam int unsigned TOKEN_W_DEF = 16;
    localparam int unsigned OUT_W_DEF   = 32;
    localparam int unsigned STRB_W      = OUT_W_DEF / 8;
    // Tokens carried per stream word; the packer logic assumes exactly two.
    localparam int unsigned LANE_CNT    = OUT_W_DEF / TOKEN_W_DEF;

    localparam logic [STRB_W-1:0] STRB_FULL = 4'b1111;
    localparam logic [STRB_W-1:0] STRB_LOW  = 4'b0011;

    typedef struct packed {
        logic [OUT_W_DEF-1:0] data;
        logic [STRB_W-1:0]    strb;
    } packed_word_t;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Minimal HWPE stream bundle: data/strb/valid/ready between a source and a sink.
// Latency: n/a (wires only).
// Backpressure: a beat transfers when valid && ready; source holds data while stalled.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
) ();

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport source (output valid, output data, output strb, input ready);
    modport sink   (input valid, input data, input strb, output ready);

endinterface

// File: rtl/mdc_stream_fifo_sync.sv
// Synchronous FIFO of packed_word_t with soft clear; head is read straight from storage.
// Latency: a pushed word is visible on o_head one cycle after the push edge.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
// Ports: i_clk/i_rst_n/i_clear control, i_push/i_push_word write side,
//        i_pop read side, o_head/o_full/o_empty status.
module mdc_stream_fifo_sync
    import mdc_stream_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clear,
    input  logic         i_push,
    input  packed_word_t i_push_word,
    input  logic         i_pop,
    output packed_word_t o_head,
    output logic         o_full,
    output logic         o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    packed_word_t   r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    // Full + simultaneous pop frees the slot being written this cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Head is forced to zero when empty so the idle bus reads all-zero.
    assign o_head = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers are AW bits wide, so they wrap at DEPTH (power of two).
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: reads are masked while the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_push_word;
        end
    end

endmodule

// File: rtl/mdc_stream_out_packer.sv
// Packs pairs of 16-bit actor tokens into 32-bit stream words, with strobe-masked flush of a lone token.
// Latency: word appears on out one cycle after the completing token or flush push.
// Backpressure: in_ready_o drops while the FIFO is full, a flush is pending, or clear_i is high.
// Ports: clk_i/rst_ni/clear_i control; in_data_i/in_valid_i/in_ready_o token input;
//        flush_i end-of-frame pulse; out packed stream source; busy_o activity; word_cnt_o beats sent.
module mdc_stream_out_packer
    import mdc_stream_pkg::*;
#(
    parameter int unsigned TOKEN_W    = 16,
    parameter int unsigned OUT_W      = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic [TOKEN_W-1:0] in_data_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic               flush_i,
    hwpe_stream_intf_stream.source out,
    output logic               busy_o,
    output logic [CNT_W-1:0]   word_cnt_o
);

    localparam int unsigned HALF_W = OUT_W / 2;

    logic [TOKEN_W-1:0] r_lane;
    logic               r_lane_full;
    logic               r_flush_pending;
    logic [CNT_W-1:0]   r_word_cnt;

    logic         w_tok_hs;
    logic         w_push_full;
    logic         w_push_part;
    logic         w_push;
    logic         w_flush_done;
    logic         w_pop;
    logic         w_fifo_full;
    logic         w_fifo_empty;
    packed_word_t w_push_word;
    packed_word_t w_head;

    // Token acceptance also waits on !fifo_full when it only fills the lane,
    // so the FIFO only ever needs one push port.
    assign in_ready_o  = !w_fifo_full && !r_flush_pending && !clear_i;
    assign w_tok_hs    = in_valid_i && in_ready_o;

    // in_ready_o is low while a flush is pending, so the two push sources
    // are mutually exclusive.
    assign w_push_full  = w_tok_hs && r_lane_full;
    assign w_push_part  = r_flush_pending && r_lane_full && !w_fifo_full;
    assign w_push       = w_push_full || w_push_part;
    assign w_flush_done = r_flush_pending && (!r_lane_full || !w_fifo_full);

    always_comb begin
        w_push_word = '0;
        if (w_push_full) begin
            w_push_word.data = {in_data_i, r_lane};
            w_push_word.strb = STRB_FULL;
        end else if (w_push_part) begin
            w_push_word.data = {{HALF_W{1'b0}}, r_lane};
            w_push_word.strb = STRB_LOW;
        end
    end

    mdc_stream_fifo_sync #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (clk_i),
        .i_rst_n     (rst_ni),
        .i_clear     (clear_i),
        .i_push      (w_push),
        .i_push_word (w_push_word),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    assign out.valid = !w_fifo_empty;
    assign out.data  = w_head.data;
    assign out.strb  = w_head.strb;
    assign w_pop     = !w_fifo_empty && out.ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lane          <= '0;
            r_lane_full     <= 1'b0;
            r_flush_pending <= 1'b0;
            r_word_cnt      <= '0;
        end else if (clear_i) begin
            r_lane          <= '0;
            r_lane_full     <= 1'b0;
            r_flush_pending <= 1'b0;
            r_word_cnt      <= '0;
        end else begin
            if (w_tok_hs) begin
                if (!r_lane_full) begin
                    r_lane      <= in_data_i;
                    r_lane_full <= 1'b1;
                end else begin
                    r_lane_full <= 1'b0;
                end
            end else if (w_push_part) begin
                r_lane_full <= 1'b0;
            end

            // A flush pulse seen while one is already pending is dropped.
            if (r_flush_pending) begin
                if (w_flush_done) r_flush_pending <= 1'b0;
            end else if (flush_i) begin
                r_flush_pending <= 1'b1;
            end

            if (w_pop) r_word_cnt <= r_word_cnt + CNT_W'(1);
        end
    end

    assign busy_o     = r_lane_full || !w_fifo_empty || r_flush_pending;
    assign word_cnt_o = r_word_cnt;

endmodule

// File: tb/tb_mdc_stream_out_packer.sv
module tb_mdc_stream_out_packer;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic        busy;
    logic [3:0]  word_cnt;

    int n_cmp = 0;
    int n_err = 0;

    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) out_if ();

    mdc_stream_out_packer #(
        .TOKEN_W    (16),
        .OUT_W      (32),
        .FIFO_DEPTH (4),
        .CNT_W      (4)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .clear_i    (clear),
        .in_data_i  (in_data),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .flush_i    (flush),
        .out        (out_if),
        .busy_o     (busy),
        .word_cnt_o (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one token (optionally with flush) and returns 1 time unit after its handshake edge.
    task automatic send_tok(input logic [15:0] d, input logic fl);
        int k;
        in_data  = d;
        in_valid = 1'b1;
        flush    = fl;
        k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        if (k >= 50) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_tok_timeout: in_ready stayed 0 for token %h", d);
        end
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        if (out_if.valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", out_if.valid); end
        n_cmp++;
        if (out_if.data !== 32'h0) begin n_err++; $display("FAIL rst_data: got %h want 0", out_if.data); end
        n_cmp++;
        if (out_if.strb !== 4'h0) begin n_err++; $display("FAIL rst_strb: got %b want 0", out_if.strb); end
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++;
        if (word_cnt !== 4'd0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", word_cnt); end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_cmp++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_pair();
        out_if.ready = 1'b1;
        send_tok(16'h1111, 1'b0);
        send_tok(16'h2222, 1'b0);
        if (out_if.valid !== 1'b1) begin n_err++; $display("FAIL pair_valid: got %b want 1", out_if.valid); end
        n_cmp++;
        if ({out_if.data, out_if.strb} !== {32'h22221111, 4'b1111}) begin
            n_err++; $display("FAIL pair_word: got %h/%b want 22221111/1111", out_if.data, out_if.strb);
        end
        n_cmp++;
        tick();
        if (word_cnt !== 4'd1) begin n_err++; $display("FAIL pair_cnt: got %0d want 1", word_cnt); end
        n_cmp++;
        if (out_if.valid !== 1'b0) begin n_err++; $display("FAIL pair_drain: got %b want 0", out_if.valid); end
        n_cmp++;
    endtask

    task automatic test_flush();
        out_if.ready = 1'b0;
        send_tok(16'hAAAA, 1'b0);
        send_tok(16'hBBBB, 1'b0);
        send_tok(16'hCCCC, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_pend_ready: got %b want 0", in_ready); end
        n_cmp++;
        tick();
        if (busy !== 1'b1) begin n_err++; $display("FAIL flush_busy: got %b want 1", busy); end
        n_cmp++;
        if ({out_if.data, out_if.strb} !== {32'hBBBBAAAA, 4'b1111}) begin
            n_err++; $display("FAIL flush_word0: got %h/%b want BBBBAAAA/1111", out_if.data, out_if.strb);
        end
        n_cmp++;
        out_if.ready = 1'b1;
        tick();
        if ({out_if.valid, out_if.data, out_if.strb} !== {1'b1, 32'h0000CCCC, 4'b0011}) begin
            n_err++; $display("FAIL flush_word1: got %b %h/%b want 1 0000CCCC/0011", out_if.valid, out_if.data, out_if.strb);
        end
        n_cmp++;
        tick();
        if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy_end: got %b want 0", busy); end
        n_cmp++;
        if (word_cnt !== 4'd3) begin n_err++; $display("FAIL flush_cnt: got %0d want 3", word_cnt); end
        n_cmp++;
    endtask

    task automatic test_stall();
        logic [35:0] exp_w [5];
        for (int i = 0; i < 5; i++) begin
            exp_w[i] = {16'h0A01 + 16'(2*i), 16'h0A00 + 16'(2*i), 4'b1111};
        end
        out_if.ready = 1'b0;
        for (int i = 0; i < 8; i++) send_tok(16'h0A00 + 16'(i), 1'b0);
        in_data  = 16'h0A08;
        in_valid = 1'b1;
        #1;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_full_ready: got %b want 0", in_ready); end
        n_cmp++;
        repeat (3) tick();
        if ({out_if.valid, out_if.data, out_if.strb} !== {1'b1, exp_w[0]}) begin
            n_err++; $display("FAIL stall_hold: got %b %h/%b want 1 %h", out_if.valid, out_if.data, out_if.strb, exp_w[0]);
        end
        n_cmp++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready_hold: got %b want 0", in_ready); end
        n_cmp++;
        out_if.ready = 1'b1;
        fork
            begin
                send_tok(16'h0A08, 1'b0);
                send_tok(16'h0A09, 1'b0);
            end
            begin
                int got;
                got = 0;
                for (int c = 0; c < 40 && got < 5; c++) begin
                    @(negedge clk);
                    if (out_if.valid && out_if.ready) begin
                        if ({out_if.data, out_if.strb} !== exp_w[got]) begin
                            n_err++; $display("FAIL stall_order%0d: got %h/%b want %h", got, out_if.data, out_if.strb, exp_w[got]);
                        end
                        n_cmp++;
                        got++;
                    end
                end
                if (got != 5) begin n_err++; $display("FAIL stall_count: got %0d words want 5", got); end
                n_cmp++;
            end
        join
        repeat (2) tick();
        if (word_cnt !== 4'd8) begin n_err++; $display("FAIL stall_cnt: got %0d want 8", word_cnt); end
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL stall_busy: got %b want 0", busy); end
        n_cmp++;
    endtask

    task automatic test_flush_same_cycle();
        out_if.ready = 1'b1;
        send_tok(16'h1234, 1'b0);
        send_tok(16'h5678, 1'b1);
        if ({out_if.valid, out_if.data, out_if.strb} !== {1'b1, 32'h56781234, 4'b1111}) begin
            n_err++; $display("FAIL fsame_word: got %b %h/%b want 1 56781234/1111", out_if.valid, out_if.data, out_if.strb);
        end
        n_cmp++;
        repeat (3) tick();
        if (word_cnt !== 4'd9) begin n_err++; $display("FAIL fsame_cnt: got %0d want 9", word_cnt); end
        n_cmp++;
        if ({out_if.valid, busy} !== 2'b00) begin n_err++; $display("FAIL fsame_idle: got %b%b want 00", out_if.valid, busy); end
        n_cmp++;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        if (busy !== 1'b1) begin n_err++; $display("FAIL fempty_pend: got %b want 1", busy); end
        n_cmp++;
        repeat (3) tick();
        if ({out_if.valid, busy, word_cnt} !== {2'b00, 4'd9}) begin
            n_err++; $display("FAIL fempty_noword: got v=%b b=%b cnt=%0d want 0 0 9", out_if.valid, busy, word_cnt);
        end
        n_cmp++;
    endtask

    task automatic test_reset_midframe();
        out_if.ready = 1'b0;
        for (int i = 0; i < 5; i++) send_tok(16'h3000 + 16'(i), 1'b0);
        if ({out_if.valid, busy} !== 2'b11) begin n_err++; $display("FAIL mid_prefill: got %b%b want 11", out_if.valid, busy); end
        n_cmp++;
        rst_n = 1'b0;
        #1;
        if ({out_if.valid, out_if.data, word_cnt, busy} !== {1'b0, 32'h0, 4'd0, 1'b0}) begin
            n_err++; $display("FAIL mid_rst: got v=%b d=%h cnt=%0d b=%b want 0 0 0 0", out_if.valid, out_if.data, word_cnt, busy);
        end
        n_cmp++;
        tick();
        rst_n = 1'b1;
        out_if.ready = 1'b1;
        tick();
        send_tok(16'h7777, 1'b0);
        send_tok(16'h8888, 1'b0);
        if ({out_if.valid, out_if.data, out_if.strb} !== {1'b1, 32'h88887777, 4'b1111}) begin
            n_err++; $display("FAIL mid_fresh: got %b %h/%b want 1 88887777/1111", out_if.valid, out_if.data, out_if.strb);
        end
        n_cmp++;
        tick();
        if (word_cnt !== 4'd1) begin n_err++; $display("FAIL mid_cnt: got %0d want 1", word_cnt); end
        n_cmp++;
    endtask

    task automatic test_clear_and_wrap();
        out_if.ready = 1'b1;
        send_tok(16'h4444, 1'b0);
        clear = 1'b1;
        #1;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL clr_ready: got %b want 0", in_ready); end
        n_cmp++;
        tick();
        clear = 1'b0;
        if ({word_cnt, busy} !== {4'd0, 1'b0}) begin n_err++; $display("FAIL clr_state: got cnt=%0d b=%b want 0 0", word_cnt, busy); end
        n_cmp++;
        for (int i = 0; i < 34; i++) send_tok(16'h5000 + 16'(i), 1'b0);
        repeat (3) tick();
        if (word_cnt !== 4'd1) begin n_err++; $display("FAIL wrap_cnt: got %0d want 1", word_cnt); end
        n_cmp++;
    endtask

    initial begin
        rst_n        = 1'b0;
        clear        = 1'b0;
        in_data      = 16'h0;
        in_valid     = 1'b0;
        flush        = 1'b0;
        out_if.ready = 1'b0;
        test_reset();
        test_pair();
        test_flush();
        test_stall();
        test_flush_same_cycle();
        test_reset_midframe();
        test_clear_and_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
